// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared state encodings and widths for mux_rr_arbiter
package mux_arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CH0  = 2'b01,
        ST_CH1  = 2'b10
    } state_e;
    localparam int BURST_CW = 3;
    localparam int STATS_W  = 16;
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: FIFO-side and downstream signals of mux_rr_arbiter; MUX_ARB_STATS_EN adds grant/stall counters
interface mux_rr_arbiter_if import mux_arb_pkg::*; #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty_0;
    logic                  fifo_empty_1;
    logic [DATA_WIDTH-1:0] data_in_0;
    logic [DATA_WIDTH-1:0] data_in_1;
    logic                  almost_full_out;
    logic                  pop_0;
    logic                  pop_1;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  active_ch;
`ifdef MUX_ARB_STATS_EN
    logic [STATS_W-1:0]    grant_cnt_0;
    logic [STATS_W-1:0]    grant_cnt_1;
    logic [STATS_W-1:0]    stall_cnt;
    modport slave (
        input  fifo_empty_0, fifo_empty_1, data_in_0, data_in_1, almost_full_out,
        output pop_0, pop_1, data_out, valid_out, active_ch, grant_cnt_0, grant_cnt_1, stall_cnt
    );
    modport master (
        output fifo_empty_0, fifo_empty_1, data_in_0, data_in_1, almost_full_out,
        input  pop_0, pop_1, data_out, valid_out, active_ch, grant_cnt_0, grant_cnt_1, stall_cnt
    );
`else
    modport slave (
        input  fifo_empty_0, fifo_empty_1, data_in_0, data_in_1, almost_full_out,
        output pop_0, pop_1, data_out, valid_out, active_ch
    );
    modport master (
        output fifo_empty_0, fifo_empty_1, data_in_0, data_in_1, almost_full_out,
        input  pop_0, pop_1, data_out, valid_out, active_ch
    );
`endif
endinterface

// File: rtl/arb_burst_cnt.sv
// arb_burst_cnt: saturating burst counter with clear and enable, flags when the burst limit is reached
module arb_burst_cnt import mux_arb_pkg::*; #(
    parameter int LIMIT = 3
) (
    input  logic clk,
    input  logic reset_L,
    input  logic i_clr,
    input  logic i_en,
    output logic o_at_limit
);
    localparam logic [BURST_CW-1:0] L_LIMIT = BURST_CW'(LIMIT);
    logic [BURST_CW-1:0] r_cnt;
    assign o_at_limit = r_cnt == L_LIMIT;
    // count pops, saturating at the limit; clear takes priority over enable
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)                    r_cnt <= '0;
        else if (i_clr)                  r_cnt <= '0;
        else if (i_en && !o_at_limit)    r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin, burst-limited arbiter popping two FIFOs onto a registered output; MUX_ARB_STATS_EN adds grant/stall counters
module mux_rr_arbiter import mux_arb_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input logic             clk,
    input logic             reset_L,
    mux_rr_arbiter_if.slave bus
);
    state_e                r_state;
    state_e                w_next;
    state_e                w_other;
    logic                  r_last_ch;
    logic                  r_valid;
    logic                  r_active_ch;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_in_ch;
    logic                  w_cur;
    logic                  w_own_empty;
    logic                  w_oth_empty;
    logic                  w_pop;
    logic                  w_at_limit;
    logic                  w_clr;

    assign w_in_ch     = r_state != ST_IDLE;
    assign w_cur       = r_state == ST_CH1;
    assign w_own_empty = w_cur ? bus.fifo_empty_1 : bus.fifo_empty_0;
    assign w_oth_empty = w_cur ? bus.fifo_empty_0 : bus.fifo_empty_1;
    assign w_other     = w_cur ? ST_CH0 : ST_CH1;
    assign w_pop       = w_in_ch && !w_own_empty && !bus.almost_full_out;
    assign bus.pop_0   = reset_L && w_pop && !w_cur;
    assign bus.pop_1   = reset_L && w_pop && w_cur;
    assign bus.data_out  = r_data;
    assign bus.valid_out = r_valid;
    assign bus.active_ch = r_active_ch;
    // any state change (or idling) restarts the burst count for the next grant
    assign w_clr = !w_in_ch || (w_next != r_state);

    arb_burst_cnt #(.LIMIT(BURST_MAX - 1)) u_burst (
        .clk        (clk),
        .reset_L    (reset_L),
        .i_clr      (w_clr),
        .i_en       (w_pop),
        .o_at_limit (w_at_limit)
    );

    // state register
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // next state: fair pick from IDLE, then backpressure, burst limit, drain handling in priority order
    always_comb begin
        w_next = r_state;
        if (!w_in_ch) begin
            if (!bus.fifo_empty_0 && !bus.fifo_empty_1) w_next = r_last_ch ? ST_CH0 : ST_CH1;
            else if (!bus.fifo_empty_0)                 w_next = ST_CH0;
            else if (!bus.fifo_empty_1)                 w_next = ST_CH1;
        end
        else if (bus.almost_full_out)                   w_next = r_state;
        else if (w_pop && w_at_limit && !w_oth_empty)   w_next = w_other;
        else if (w_own_empty && !w_oth_empty)           w_next = w_other;
        else if (w_own_empty && w_oth_empty)            w_next = ST_IDLE;
    end

    // register the popped word with its channel; valid drops on any non-pop cycle
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_active_ch <= 1'b0;
            r_last_ch   <= 1'b1;
        end
        else if (w_pop) begin
            r_data      <= w_cur ? bus.data_in_1 : bus.data_in_0;
            r_valid     <= 1'b1;
            r_active_ch <= w_cur;
            r_last_ch   <= w_cur;
        end
        else r_valid <= 1'b0;
    end

`ifdef MUX_ARB_STATS_EN
    logic [STATS_W-1:0] r_grant_0;
    logic [STATS_W-1:0] r_grant_1;
    logic [STATS_W-1:0] r_stall;
    assign bus.grant_cnt_0 = r_grant_0;
    assign bus.grant_cnt_1 = r_grant_1;
    assign bus.stall_cnt   = r_stall;
    // wrapping per-channel pop counts and backpressure cycles while granted
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_grant_0 <= '0;
            r_grant_1 <= '0;
            r_stall   <= '0;
        end
        else begin
            if (w_pop && !w_cur)                 r_grant_0 <= r_grant_0 + 1'b1;
            if (w_pop && w_cur)                  r_grant_1 <= r_grant_1 + 1'b1;
            if (w_in_ch && bus.almost_full_out)  r_stall   <= r_stall + 1'b1;
        end
    end
`endif
endmodule
